// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches words over a req/ack handshake,
// holds the fetched word for decode, and traps misaligned next-PC selections.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        PCSrc,
  input  logic [31:0] PCTarget,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instr,
  output logic [31:0] PC,
  output logic [31:0] PCPlus4,
  output logic        instr_valid,
  output logic        misalign_flt,
  output logic [31:0] retired_cnt
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_VALID = 2'd1,
    S_FAULT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        flt_q, flt_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        consume;

  assign pc_plus4 = pc_q + 32'd4;
  assign next_pc  = PCSrc ? PCTarget : pc_plus4;
  assign consume  = (state_q == S_VALID) && !stall;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    flt_d   = flt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_REQ: begin
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_VALID;
        end
      end
      S_VALID: begin
        if (consume) begin
          cnt_d   = cnt_q + 32'd1;
          pc_d    = next_pc;
          instr_d = NOP_INSTR;
          if (next_pc[1:0] == 2'b00) begin
            state_d = S_REQ;
          end else begin
            flt_d   = 1'b1;
            state_d = S_FAULT;
          end
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      flt_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      flt_q   <= flt_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request is masked during reset so nothing is issued in the reset cycle itself.
  assign imem_req     = (state_q == S_REQ) && !reset;
  assign imem_addr    = pc_q;
  assign Instr        = instr_q;
  assign PC           = pc_q;
  assign PCPlus4      = pc_plus4;
  assign instr_valid  = (state_q == S_VALID);
  assign misalign_flt = flt_q;
  assign retired_cnt  = cnt_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a transaction-level reference model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, PCSrc, imem_ack;
  logic [31:0] PCTarget, imem_rdata;
  logic        imem_req, instr_valid, misalign_flt;
  logic [31:0] imem_addr, Instr, PC, PCPlus4, retired_cnt;

  fetch_unit #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk(clk), .reset(reset), .stall(stall), .PCSrc(PCSrc), .PCTarget(PCTarget),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4),
    .instr_valid(instr_valid), .misalign_flt(misalign_flt), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: "holding a word" and "trapped" flags plus architectural values.
  bit          m_known = 0;
  bit          m_have, m_trap, m_flt;
  logic [31:0] m_pc, m_instr, m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, compare every output with the model, then advance both.
  task automatic step(input bit rst, input bit stl, input bit src,
                      input logic [31:0] tgt, input bit ack, input logic [31:0] rd);
    logic [31:0] nxt;
    reset = rst; stall = stl; PCSrc = src; PCTarget = tgt;
    imem_ack = ack; imem_rdata = rd;
    #1;
    chk("req", {31'd0, imem_req}, {31'd0, (!rst && m_known && !m_have && !m_trap)});
    if (m_known) begin
      if (imem_req) chk("addr", imem_addr, m_pc);
      chk("valid", {31'd0, instr_valid}, {31'd0, m_have});
      chk("pc", PC, m_pc);
      chk("pc4", PCPlus4, m_pc + 32'd4);
      chk("instr", Instr, m_instr);
      chk("flt", {31'd0, misalign_flt}, {31'd0, m_flt});
      chk("cnt", retired_cnt, m_cnt);
    end
    @(posedge clk);
    if (rst) begin
      m_known = 1; m_have = 0; m_trap = 0; m_flt = 0;
      m_pc = RESET_PC; m_instr = NOP_INSTR; m_cnt = 0;
    end else if (m_known && !m_trap) begin
      if (!m_have) begin
        if (ack) begin m_instr = rd; m_have = 1; end
      end else if (!stl) begin
        nxt = src ? tgt : m_pc + 32'd4;
        m_cnt = m_cnt + 1;
        m_pc = nxt;
        m_instr = NOP_INSTR;
        m_have = 0;
        if (nxt[1:0] != 2'b00) begin m_flt = 1; m_trap = 1; end
      end
    end
    #1;
  endtask

  initial begin
    logic [31:0] t;
    logic [31:0] held_instr;
    reset = 1; stall = 0; PCSrc = 0; PCTarget = 0; imem_ack = 0; imem_rdata = 0;
    #1;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 32'h1111_1111);

    // Zero-wait sequential fetch: requests for 0,4,8 every other cycle.
    for (int unsigned i = 0; i < 6; i++) step(0, 0, 0, 0, 1, 32'hA000_0000 + i);
    chk("cnt3", retired_cnt, 32'd3);

    // Three-cycle memory wait, then spurious ack while valid.
    for (int unsigned i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 32'hFFFF_FFFF);
    step(0, 1, 0, 0, 1, 32'h1234_5678);
    held_instr = Instr;
    chk("capt", held_instr, 32'h1234_5678);
    step(0, 1, 1, 32'h200, 1, 32'hDEAD_BEEF);
    chk("spur", Instr, 32'h1234_5678);

    // Stall with PCSrc toggling, then redirect to 0x100.
    for (int unsigned i = 0; i < 4; i++) step(0, 1, i[0], 32'h300, 0, 0);
    step(0, 0, 1, 32'h100, 0, 0);
    chk("redir", imem_addr, 32'h100);

    // Wrap of PCPlus4 at the top of the address space.
    step(0, 0, 0, 0, 1, 32'h5);
    step(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    chk("wrap", PCPlus4, 32'h0);

    // Misaligned target traps until reset.
    step(0, 0, 0, 0, 1, 32'h6);
    step(0, 0, 1, 32'h102, 0, 0);
    chk("fpc", PC, 32'h102);
    for (int unsigned i = 0; i < 5; i++) step(0, 0, 0, 0, 1, 32'h7);

    // Reset in S_REQ with a concurrent ack is discarded.
    step(1, 0, 0, 0, 1, 32'h8);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 32'h9);
    chk("rstinstr", Instr, NOP_INSTR);

    // Randomized traffic.
    for (int unsigned i = 0; i < 4000; i++) begin
      t = $urandom;
      if ($urandom_range(0, 19) != 0) t[1:0] = 2'b00;
      step(($urandom_range(0, 99) == 0) || (m_trap && $urandom_range(0, 7) == 0),
           $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1, t,
           $urandom_range(0, 1) == 1, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
